// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, oversampling rate
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int unsigned OVERSAMPLE = 32'd16;

    // Parity over the low dbit bits; odd mode inverts the even result.
    function automatic logic calc_parity(input logic [7:0] data, input int dbit,
                                         input logic [1:0] mode);
        logic p;
        p = 1'b0;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            if (i < dbit) begin
                p = p ^ data[i];
            end else begin
                p = p;
            end
        end
        if (mode == PAR_ODD) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit,
// stop bit of SB_TICK oversample ticks. The line is driven from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam logic [4:0] LAST_OS_TICK   = 5'(OVERSAMPLE - 32'd1);
    localparam logic [4:0] LAST_STOP_TICK = 5'(SB_TICK - 32'sd1);
    localparam logic [2:0] LAST_BIT       = 3'(DBIT - 32'sd1);
    localparam logic [1:0] PAR_MODE       = 2'(PARITY);

    uart_state_e state_q, state_d;
    logic [4:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q;
    logic        done_s;

    // Next-state logic; done is a Mealy pulse so a coincident tx_start still sees STOP.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d = ST_START;
                    shreg_d = din;
                    par_d   = calc_parity(din, DBIT, PAR_MODE);
                    tick_d  = 5'd0;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START, ST_PARITY: begin
                if (s_tick && (tick_q == LAST_OS_TICK)) begin
                    tick_d  = 5'd0;
                    bit_d   = 3'd0;
                    state_d = (state_q == ST_START) ? ST_DATA : ST_STOP;
                end else if (s_tick) begin
                    tick_d = tick_q + 5'd1;
                end else begin
                    tick_d = tick_q;
                end
            end
            ST_DATA: begin
                if (s_tick && (tick_q == LAST_OS_TICK)) begin
                    tick_d  = 5'd0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else if (s_tick) begin
                    tick_d = tick_q + 5'd1;
                end else begin
                    tick_d = tick_q;
                end
            end
            ST_STOP: begin
                if (s_tick && (tick_q == LAST_STOP_TICK)) begin
                    tick_d  = 5'd0;
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else if (s_tick) begin
                    tick_d = tick_q + 5'd1;
                end else begin
                    tick_d = tick_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the current state, registered one clk later.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tick_q  <= 5'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances cover default, even/odd parity
// and a 7-bit / 2-stop configuration; s_tick pulses every 4 clk.
module tb_uart_tx;

    localparam int BUF = 1500;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tick_cnt = 2'd0;
    logic       s_tick;
    logic [3:0] tx_start_v;
    logic [7:0] din;
    logic [3:0] tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic val;
        int   clks;
    } seg_t;

    seg_t seg_q[$];
    int   done_q[$];
    int   exp_pos;

    logic line_buf [0:BUF-1];
    logic done_buf [0:BUF-1];
    logic busy_buf [0:BUF-1];

    always #5 clk = ~clk;

    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign s_tick = (tick_cnt == 2'd3);

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[0]), .din(din),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut_even (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[1]), .din(din),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut_odd (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[2]), .din(din),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY(0)) dut7 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[3]), .din(din),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

    // Reference line model: one segment per bit, durations in clk (4 clk per tick).
    function automatic void push_frame(input logic [7:0] data, input int dbit, input int par,
                                       input int sb, input int start_clks);
        seg_t s;
        logic p;
        p = 1'b0;
        s.val = 1'b0; s.clks = start_clks; seg_q.push_back(s);
        for (int i = 0; i < dbit; i++) begin
            s.val = data[i]; s.clks = 64; seg_q.push_back(s);
            p = p ^ data[i];
        end
        if (par != 0) begin
            s.val = (par == 2) ? ~p : p; s.clks = 64; seg_q.push_back(s);
        end
        s.val = 1'b1; s.clks = 4 * sb; seg_q.push_back(s);
        exp_pos = exp_pos + start_clks + 64 * dbit + ((par != 0) ? 64 : 0) + 4 * sb;
        done_q.push_back(exp_pos - 2);
    endfunction

    function automatic void push_idle(input int n);
        seg_t s;
        s.val = 1'b1; s.clks = n; seg_q.push_back(s);
        exp_pos = exp_pos + n;
    endfunction

    function automatic int count_diff(input int start, input int len, input logic val);
        int n;
        n = 0;
        for (int i = 0; i < len; i++) begin
            if (start + i >= BUF) n++;
            else if (line_buf[start + i] !== val) n++;
        end
        return n;
    endfunction

    function automatic int count_done(input int len);
        int n;
        n = 0;
        for (int i = 0; i < len; i++) if (done_buf[i] === 1'b1) n++;
        return n;
    endfunction

    // Request a frame so that acceptance coincides with an s_tick edge.
    task automatic send(input int which, input logic [7:0] data, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        while (s_tick !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        din = data;
        tx_start_v[which] = 1'b1;
        @(negedge clk);
        if (!hold) tx_start_v[which] = 1'b0;
    endtask

    // Wait for the start-bit falling edge, then record len samples (index 0 = first low sample).
    task automatic capture(input int which, input int len, output bit ok);
        int   w;
        logic prev;
        ok = 1'b0;
        w = 0;
        prev = tx_v[which];
        while (!ok && w < 300) begin
            @(negedge clk);
            if (prev === 1'b1 && tx_v[which] === 1'b0) ok = 1'b1;
            else begin
                prev = tx_v[which];
                w++;
            end
        end
        if (ok) begin
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge clk);
                line_buf[k] = tx_v[which];
                done_buf[k] = done_v[which];
                busy_buf[k] = busy_v[which];
            end
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy_v !== 4'h0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (busy_v !== 4'h0) begin
            errors++;
            $display("FAIL idle_timeout: tx_busy=%b required 0000", busy_v);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx_v !== 4'hF) begin errors++; $display("FAIL reset_tx: tx=%b required 1111", tx_v); end
        checks++;
        if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy: busy=%b required 0000", busy_v); end
        checks++;
        if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done: done=%b required 0000", done_v); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_v !== 4'hF || busy_v !== 4'h0) begin
            errors++;
            $display("FAIL idle_hold: tx=%b busy=%b required 1111/0000", tx_v, busy_v);
        end
    endtask

    task automatic test_basic();
        bit ok; int n, pos, idx; seg_t s;
        exp_pos = 0;
        push_frame(8'hA5, 8, 0, 16, 64);
        send(0, 8'hA5, 1'b0);
        capture(0, 720, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_start: no start bit within budget");
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL basic_line@%0d: %0d of %0d clk differ, required level %b", pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(720); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL basic_done_count: %0d pulses, required %0d", n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL basic_done_at%0d: done=%b required 1", idx, done_buf[idx]); end
            end
            checks++;
            if ({busy_buf[0], busy_buf[638], busy_buf[639]} !== 3'b110) begin
                errors++;
                $display("FAIL basic_busy: busy[0,638,639]=%b%b%b required 110", busy_buf[0], busy_buf[638], busy_buf[639]);
            end
        end
        wait_idle();
    endtask

    task automatic test_parity(input int which, input int mode);
        bit ok; int n, pos, idx; seg_t s;
        exp_pos = 0;
        push_frame(8'h07, 8, mode, 16, 64);
        send(which, 8'h07, 1'b0);
        capture(which, 720, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL parity%0d_start: no start bit within budget", mode);
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL parity%0d_line@%0d: %0d of %0d clk differ, required level %b", mode, pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(720); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL parity%0d_done_count: %0d pulses, required %0d", mode, n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL parity%0d_done_at%0d: done=%b required 1", mode, idx, done_buf[idx]); end
            end
        end
        wait_idle();
    endtask

    task automatic test_din_change();
        bit ok; int n, pos, idx; seg_t s;
        exp_pos = 0;
        push_frame(8'h3C, 8, 0, 16, 64);
        send(0, 8'h3C, 1'b1);
        fork
            capture(0, 720, ok);
            begin
                repeat (600) begin
                    @(negedge clk);
                    din = 8'($urandom);
                end
                tx_start_v[0] = 1'b0;
            end
        join
        checks++;
        if (!ok) begin
            errors++; $display("FAIL hold_start: no start bit within budget");
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL hold_line@%0d: %0d of %0d clk differ, required level %b", pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(720); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL hold_done_count: %0d pulses, required %0d", n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL hold_done_at%0d: done=%b required 1", idx, done_buf[idx]); end
            end
            checks++;
            if (busy_buf[719] !== 1'b0) begin errors++; $display("FAIL hold_extra_frame: busy=%b at end, required 0", busy_buf[719]); end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit ok; int n, pos, idx; seg_t s;
        exp_pos = 0;
        push_frame(8'hC3, 8, 0, 16, 64);
        push_idle(1);
        push_frame(8'hC3, 8, 0, 16, 63);
        send(0, 8'hC3, 1'b1);
        fork
            capture(0, 1400, ok);
            begin
                repeat (700) @(negedge clk);
                tx_start_v[0] = 1'b0;
            end
        join
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_start: no start bit within budget");
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL b2b_line@%0d: %0d of %0d clk differ, required level %b", pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(1400); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL b2b_done_count: %0d pulses, required %0d", n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL b2b_done_at%0d: done=%b required 1", idx, done_buf[idx]); end
            end
            checks++;
            if ({busy_buf[638], busy_buf[639], busy_buf[640]} !== 3'b101) begin
                errors++;
                $display("FAIL b2b_gap: busy[638..640]=%b%b%b required 101", busy_buf[638], busy_buf[639], busy_buf[640]);
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int n, pos, idx, seen; seg_t s;
        send(0, 8'hF0, 1'b0);
        capture(0, 280, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_start: no start bit within budget"); end
        else if (tx_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_bit3: tx=%b required 0", tx_v[0]); end
        reset = 1'b1;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx: tx=%b required 1", tx_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy: busy=%b required 0", busy_v[0]); end
        seen = 0;
        repeat (4) begin @(negedge clk); if (done_v[0] !== 1'b0) seen++; end
        reset = 1'b0;
        repeat (60) begin @(negedge clk); if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: %0d bad samples, required 0", seen); end
        exp_pos = 0;
        push_frame(8'h5A, 8, 0, 16, 64);
        send(0, 8'h5A, 1'b0);
        capture(0, 720, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midrst_next_start: no start bit within budget");
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL midrst_line@%0d: %0d of %0d clk differ, required level %b", pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(720); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL midrst_done_count: %0d pulses, required %0d", n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL midrst_done_at%0d: done=%b required 1", idx, done_buf[idx]); end
            end
        end
        wait_idle();
    endtask

    task automatic test_dbit7_stop2();
        bit ok; int n, pos, idx; seg_t s;
        exp_pos = 0;
        push_frame(8'hFF, 7, 0, 32, 64);
        send(3, 8'hFF, 1'b0);
        capture(3, 720, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL d7_start: no start bit within budget");
            seg_q.delete(); done_q.delete();
        end else begin
            pos = 0;
            while (seg_q.size() > 0) begin
                s = seg_q.pop_front(); n = count_diff(pos, s.clks, s.val); checks++;
                if (n !== 0) begin errors++; $display("FAIL d7_line@%0d: %0d of %0d clk differ, required level %b", pos, n, s.clks, s.val); end
                pos += s.clks;
            end
            n = count_done(720); checks++;
            if (n !== done_q.size()) begin errors++; $display("FAIL d7_done_count: %0d pulses, required %0d", n, done_q.size()); end
            while (done_q.size() > 0) begin
                idx = done_q.pop_front(); checks++;
                if (done_buf[idx] !== 1'b1) begin errors++; $display("FAIL d7_done_at%0d: done=%b required 1", idx, done_buf[idx]); end
            end
        end
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tx_start_v = 4'h0;
        din = 8'h00;
        test_reset();
        test_basic();
        test_parity(1, 1);
        test_parity(2, 2);
        test_din_change();
        test_back_to_back();
        test_reset_mid_frame();
        test_dbit7_stop2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
